match_controller: RTL and testbench

Parametrised round/match sequencer for N fighters. It supersedes the ad-hoc hold-to-reset timer and the single-KO winner flag.
- Watches every player's health on the game tick and runs a round countdown.
- Decides KO, timeout and draw outcomes, and tallies round wins to a best-of match.
- Drives round_rst into the physics and health blocks, plus freeze to the movement handlers.

---
 rtl/match_pkg.sv | 24 ++
 rtl/match_controller_if.sv | 31 +++
 rtl/match_controller_hold_detect.sv | 41 ++++
 rtl/match_controller.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_match_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/match_pkg.sv
// Shared types and helpers for the match controller: state encoding, win-counter
// width and the index-width helper.
package match_pkg;

  typedef enum logic [2:0] {
    ST_INTRO      = 3'd0,
    ST_FIGHT      = 3'd1,
    ST_ROUND_END  = 3'd2,
    ST_MATCH_OVER = 3'd3,
    ST_SUDDEN     = 3'd4
  } match_state_e;

  localparam int WIN_W = 4;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Game-side bundle of the match controller: tick/health/hold inputs and the
// round/match status outputs.
interface match_controller_if
  import match_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int HP_W        = 9
);
  logic                         tick;
  logic [NUM_PLAYERS*HP_W-1:0]  health;
  logic                         hold_req;
  logic [2:0]                   state;
  logic [3:0]                   round_num;
  logic [NUM_PLAYERS*WIN_W-1:0] wins;
  logic [6:0]                   round_secs;
  logic [1:0]                   winner_idx;
  logic                         winner_valid;
  logic                         draw;
  logic                         freeze;
  logic                         round_rst;

  modport master (
    output tick, health, hold_req,
    input  state, round_num, wins, round_secs, winner_idx, winner_valid, draw, freeze, round_rst
  );

  modport slave (
    input  tick, health, hold_req,
    output state, round_num, wins, round_secs, winner_idx, winner_valid, draw, freeze, round_rst
  );
endinterface

// File: rtl/match_controller_hold_detect.sv
// Tick-counted hold detector: fires for one tick when hold_req has been high for
// HOLD_TICKS ticks, then saturates until hold_req drops.
module hold_detect #(
  parameter int HOLD_TICKS = 40
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic hold_req_i,
  output logic fire_o
);
  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next hold count: clear on release, count ticks, stick at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_req_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != HOLD_MAX)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The firing tick is the one that brings the count up to the limit
  assign fire_o = hold_req_i & tick_i & (cnt_q == (HOLD_MAX - {{(CW-1){1'b0}}, 1'b1}));

  // Hold count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/match_controller.sv
// Round/match sequencer for NUM_PLAYERS fighters; all sequencing advances on tick.
// Define MATCH_SUDDEN_DEATH_EN to resolve timeout ties in a SUDDEN state instead of a draw.
module match_controller
  import match_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int HP_W          = 9,
  parameter int WINS_NEEDED   = 2,
  parameter int ROUND_SECS    = 60,
  parameter int TICKS_PER_SEC = 20,
  parameter int INTRO_TICKS   = 40,
  parameter int END_TICKS     = 60,
  parameter int HOLD_TICKS    = 40
) (
  input  logic             clk,
  input  logic             reset,
  match_controller_if.slave bus
);
  localparam int IDX_W    = clog2(NUM_PLAYERS);
  localparam int SPAN_A   = (INTRO_TICKS > END_TICKS) ? INTRO_TICKS : END_TICKS;
  localparam int CNT_SPAN = (SPAN_A > TICKS_PER_SEC) ? SPAN_A : TICKS_PER_SEC;
  localparam int CNT_W    = clog2(CNT_SPAN);
  localparam logic [6:0] SECS_INIT = 7'(ROUND_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]       alive;
    logic [IDX_W-1:0] alive_idx;
    logic [IDX_W-1:0] max_idx;
    logic             max_unique;
  } health_eval_t;

  // Live-player count, last live player, and whether the top health is held by one player
  function automatic health_eval_t eval_health(input logic [NUM_PLAYERS*HP_W-1:0] h);
    health_eval_t   r;
    logic [HP_W-1:0] hp;
    logic [HP_W-1:0] best;
    r    = '0;
    best = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      hp = h[p*HP_W +: HP_W];
      if (hp != '0) begin
        r.alive     = r.alive + 3'd1;
        r.alive_idx = IDX_W'(p);
      end
      if (hp > best) begin
        best         = hp;
        r.max_idx    = IDX_W'(p);
        r.max_unique = 1'b1;
      end else if (hp == best) begin
        r.max_unique = 1'b0;
      end
    end
    return r;
  endfunction

  match_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [CNT_W-1:0]                  sec_cnt_q, sec_cnt_d;
  logic [6:0]                        round_secs_q, round_secs_d;
  logic [3:0]                        round_num_q, round_num_d;
  logic [NUM_PLAYERS-1:0][WIN_W-1:0] wins_q, wins_d;
  logic [IDX_W-1:0]                  winner_idx_q, winner_idx_d;
  logic                              winner_valid_q, winner_valid_d;
  logic                              draw_q, draw_d;
  logic                              freeze_q, freeze_d;
  logic                              round_rst_q, round_rst_d;

  health_eval_t     ev_s;
  logic             hold_fire_s;
  logic             leader_found_s;
  logic [IDX_W-1:0] leader_idx_s;
  logic [6:0]       secs_next_s;
  logic             end_round_s;
  logic             award_s;
  logic [IDX_W-1:0] award_idx_s;

  hold_detect #(.HOLD_TICKS(HOLD_TICKS)) u_hold (
    .clk_i      (clk),
    .rst_ni     (reset),
    .tick_i     (bus.tick),
    .hold_req_i (bus.hold_req),
    .fire_o     (hold_fire_s)
  );

  assign ev_s = eval_health(bus.health);

  // Lowest-indexed player that has reached the match target
  always_comb begin
    leader_found_s = 1'b0;
    leader_idx_s   = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (wins_q[p] >= WIN_W'(WINS_NEEDED)) begin
        leader_found_s = 1'b1;
        leader_idx_s   = IDX_W'(p);
      end else begin
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sec_cnt_d      = sec_cnt_q;
    round_secs_d   = round_secs_q;
    round_num_d    = round_num_q;
    wins_d         = wins_q;
    winner_idx_d   = winner_idx_q;
    winner_valid_d = winner_valid_q;
    draw_d         = draw_q;
    freeze_d       = freeze_q;
    round_rst_d    = round_rst_q;
    secs_next_s    = round_secs_q;
    end_round_s    = 1'b0;
    award_s        = 1'b0;
    award_idx_s    = '0;

    if (hold_fire_s) begin
      state_d        = ST_INTRO;
      cnt_d          = '0;
      sec_cnt_d      = '0;
      round_secs_d   = SECS_INIT;
      round_num_d    = 4'd1;
      wins_d         = '0;
      winner_idx_d   = '0;
      winner_valid_d = 1'b0;
      draw_d         = 1'b0;
      freeze_d       = 1'b1;
      round_rst_d    = 1'b1;
    end else if (bus.tick) begin
      case (state_q)
        ST_INTRO: begin
          round_secs_d = SECS_INIT;
          if (cnt_q == CNT_W'(INTRO_TICKS - 1)) begin
            state_d     = ST_FIGHT;
            cnt_d       = '0;
            sec_cnt_d   = '0;
            freeze_d    = 1'b0;
            round_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_FIGHT: begin
          if (sec_cnt_q == CNT_W'(TICKS_PER_SEC - 1)) begin
            sec_cnt_d   = '0;
            secs_next_s = round_secs_q - 7'd1;
          end else begin
            sec_cnt_d = sec_cnt_q + CNT_ONE;
          end
          round_secs_d = secs_next_s;
          // KO outranks a timeout landing on the same tick
          if (ev_s.alive <= 3'd1) begin
            end_round_s = 1'b1;
            award_s     = (ev_s.alive == 3'd1);
            award_idx_s = ev_s.alive_idx;
          end else if (secs_next_s == 7'd0) begin
            if (ev_s.max_unique) begin
              end_round_s = 1'b1;
              award_s     = 1'b1;
              award_idx_s = ev_s.max_idx;
            end else begin
`ifdef MATCH_SUDDEN_DEATH_EN
              state_d = ST_SUDDEN;
`else
              end_round_s = 1'b1;
`endif
            end
          end else begin
            end_round_s = 1'b0;
          end
        end
`ifdef MATCH_SUDDEN_DEATH_EN
        ST_SUDDEN: begin
          round_secs_d = 7'd0;
          freeze_d     = 1'b0;
          if (ev_s.alive <= 3'd1) begin
            end_round_s = 1'b1;
            award_s     = (ev_s.alive == 3'd1);
            award_idx_s = ev_s.alive_idx;
          end else if (ev_s.max_unique) begin
            end_round_s = 1'b1;
            award_s     = 1'b1;
            award_idx_s = ev_s.max_idx;
          end else begin
            end_round_s = 1'b0;
          end
        end
`endif
        ST_ROUND_END: begin
          freeze_d    = 1'b1;
          round_rst_d = 1'b0;
          if (cnt_q == CNT_W'(END_TICKS - 1)) begin
            cnt_d = '0;
            if (leader_found_s) begin
              state_d        = ST_MATCH_OVER;
              winner_idx_d   = leader_idx_s;
              winner_valid_d = 1'b1;
            end else begin
              state_d        = ST_INTRO;
              round_num_d    = (round_num_q == 4'd15) ? 4'd15 : round_num_q + 4'd1;
              winner_valid_d = 1'b0;
              draw_d         = 1'b0;
              round_secs_d   = SECS_INIT;
              round_rst_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_MATCH_OVER: begin
          freeze_d = 1'b1;
        end
        default: begin
          state_d      = ST_INTRO;
          cnt_d        = '0;
          round_secs_d = SECS_INIT;
          freeze_d     = 1'b1;
          round_rst_d  = 1'b1;
        end
      endcase

      if (end_round_s) begin
        state_d  = ST_ROUND_END;
        cnt_d    = '0;
        freeze_d = 1'b1;
        if (award_s) begin
          wins_d[award_idx_s] = (wins_q[award_idx_s] == 4'd15) ? 4'd15 : wins_q[award_idx_s] + 4'd1;
          winner_idx_d        = award_idx_s;
          winner_valid_d      = 1'b1;
          draw_d              = 1'b0;
        end else begin
          winner_valid_d = 1'b0;
          draw_d         = 1'b1;
        end
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_INTRO;
      cnt_q          <= '0;
      sec_cnt_q      <= '0;
      round_secs_q   <= SECS_INIT;
      round_num_q    <= 4'd1;
      wins_q         <= '0;
      winner_idx_q   <= '0;
      winner_valid_q <= 1'b0;
      draw_q         <= 1'b0;
      freeze_q       <= 1'b1;
      round_rst_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sec_cnt_q      <= sec_cnt_d;
      round_secs_q   <= round_secs_d;
      round_num_q    <= round_num_d;
      wins_q         <= wins_d;
      winner_idx_q   <= winner_idx_d;
      winner_valid_q <= winner_valid_d;
      draw_q         <= draw_d;
      freeze_q       <= freeze_d;
      round_rst_q    <= round_rst_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.round_num    = round_num_q;
  assign bus.wins         = wins_q;
  assign bus.round_secs   = round_secs_q;
  assign bus.winner_idx   = 2'(winner_idx_q);
  assign bus.winner_valid = winner_valid_q;
  assign bus.draw         = draw_q;
  assign bus.freeze       = freeze_q;
  assign bus.round_rst    = round_rst_q;
endmodule

// File: tb/tb_match_controller.sv
// Table-driven bench for match_controller with an expected-value scoreboard queue.
module tb_match_controller;
  import match_pkg::*;

  localparam int NP   = 2;
  localparam int HP_W = 9;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] rn;
    logic [7:0] wins;
    logic [6:0] secs;
    logic [1:0] widx;
    logic       wv;
    logic       dr;
    logic       fz;
    logic       rr;
  } obs_t;

  typedef struct {
    string      name;
    logic       tk;
    logic       hold;
    logic [8:0] hp0;
    logic [8:0] hp1;
    int         n;
    obs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  obs_t  sb_q[$];
  string sb_name_q[$];
  vec_t  vecs[$];

  always #5 clk = ~clk;

  match_controller_if #(.NUM_PLAYERS(NP), .HP_W(HP_W)) bus ();

  match_controller #(.NUM_PLAYERS(NP), .HP_W(HP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic obs_t mk(input logic [2:0] st, input logic [3:0] rn, input logic [7:0] wins,
                              input logic [6:0] secs, input logic [1:0] widx, input logic wv,
                              input logic dr, input logic fz, input logic rr);
    obs_t o;
    o.st = st; o.rn = rn; o.wins = wins; o.secs = secs; o.widx = widx;
    o.wv = wv; o.dr = dr; o.fz = fz; o.rr = rr;
    return o;
  endfunction

  function automatic vec_t v(input string name, input logic tk, input logic hold,
                             input logic [8:0] hp0, input logic [8:0] hp1, input int n, input obs_t e);
    vec_t r;
    r.name = name; r.tk = tk; r.hold = hold; r.hp0 = hp0; r.hp1 = hp1; r.n = n; r.exp = e;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state; o.rn = bus.round_num; o.wins = bus.wins; o.secs = bus.round_secs;
    o.widx = bus.winner_idx; o.wv = bus.winner_valid; o.dr = bus.draw;
    o.fz = bus.freeze; o.rr = bus.round_rst;
    return o;
  endfunction

  task automatic expect_obs(input string name, input obs_t e);
    sb_q.push_back(e);
    sb_name_q.push_back(name);
  endtask

  task automatic check_pop();
    obs_t  g;
    obs_t  e;
    string nm;
    checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      g  = sample();
      e  = sb_q.pop_front();
      nm = sb_name_q.pop_front();
      // winner_idx is only meaningful while winner_valid is expected high
      if (!e.wv) begin
        g.widx = 2'd0;
        e.widx = 2'd0;
      end
      if (g == e) begin
        passed++;
      end else begin
        $display("FAIL %s: got st=%0d rn=%0d wins=%h secs=%0d widx=%0d wv=%0d dr=%0d fz=%0d rr=%0d, required st=%0d rn=%0d wins=%h secs=%0d widx=%0d wv=%0d dr=%0d fz=%0d rr=%0d",
                 nm, g.st, g.rn, g.wins, g.secs, g.widx, g.wv, g.dr, g.fz, g.rr,
                 e.st, e.rn, e.wins, e.secs, e.widx, e.wv, e.dr, e.fz, e.rr);
      end
    end
  endtask

  task automatic run(input int n, input logic tk);
    bus.tick = tk;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    bus.hold_req = x.hold;
    bus.health   = {x.hp1, x.hp0};
    expect_obs(x.name, x.exp);
    run(x.n, x.tk);
    check_pop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t rst_o;
    rst_o = mk(3'd0, 4'd1, 8'h00, 7'd60, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    vecs.push_back(v("idle_no_tick",      1'b0, 1'b0, 9'd100, 9'd100,    5, rst_o));
    vecs.push_back(v("intro_39",          1'b1, 1'b0, 9'd100, 9'd100,   39, rst_o));
    vecs.push_back(v("intro_to_fight",    1'b1, 1'b0, 9'd100, 9'd100,    1, mk(3'd1, 4'd1, 8'h00, 7'd60, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("fight_19",          1'b1, 1'b0, 9'd100, 9'd100,   19, mk(3'd1, 4'd1, 8'h00, 7'd60, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("sec_wrap",          1'b1, 1'b0, 9'd100, 9'd100,    1, mk(3'd1, 4'd1, 8'h00, 7'd59, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("ko_p0",             1'b1, 1'b0, 9'd0,   9'd100,    1, mk(3'd2, 4'd1, 8'h10, 7'd59, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("end_59",            1'b1, 1'b0, 9'd100, 9'd100,   59, mk(3'd2, 4'd1, 8'h10, 7'd59, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("end_to_intro",      1'b1, 1'b0, 9'd100, 9'd100,    1, mk(3'd0, 4'd2, 8'h10, 7'd60, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1)));
    vecs.push_back(v("intro2_fight",      1'b1, 1'b0, 9'd100, 9'd100,   40, mk(3'd1, 4'd2, 8'h10, 7'd60, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("ko2_p0",            1'b1, 1'b0, 9'd0,   9'd100,    1, mk(3'd2, 4'd2, 8'h20, 7'd60, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("match_over",        1'b1, 1'b0, 9'd100, 9'd100,   60, mk(3'd3, 4'd2, 8'h20, 7'd60, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("match_over_held",   1'b1, 1'b0, 9'd100, 9'd100,  200, mk(3'd3, 4'd2, 8'h20, 7'd60, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("hold_39",           1'b1, 1'b1, 9'd100, 9'd100,   39, mk(3'd3, 4'd2, 8'h20, 7'd60, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("hold_release",      1'b1, 1'b0, 9'd100, 9'd100,    1, mk(3'd3, 4'd2, 8'h20, 7'd60, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("hold_39_again",     1'b1, 1'b1, 9'd100, 9'd100,   39, mk(3'd3, 4'd2, 8'h20, 7'd60, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("hold_fire",         1'b1, 1'b1, 9'd100, 9'd100,    1, rst_o));
    vecs.push_back(v("hold_no_retrigger", 1'b1, 1'b1, 9'd100, 9'd100,  100, mk(3'd1, 4'd1, 8'h00, 7'd57, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("double_ko",         1'b1, 1'b0, 9'd0,   9'd0,      1, mk(3'd2, 4'd1, 8'h00, 7'd57, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0)));
    vecs.push_back(v("draw_to_intro",     1'b1, 1'b0, 9'd100, 9'd100,   60, mk(3'd0, 4'd2, 8'h00, 7'd60, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1)));
    vecs.push_back(v("intro3_fight",      1'b1, 1'b0, 9'd100, 9'd100,   40, mk(3'd1, 4'd2, 8'h00, 7'd60, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("timeout_minus1",    1'b1, 1'b0, 9'd80,  9'd50,  1199, mk(3'd1, 4'd2, 8'h00, 7'd1,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("timeout_p0",        1'b1, 1'b0, 9'd80,  9'd50,     1, mk(3'd2, 4'd2, 8'h01, 7'd0,  2'd0, 1'b1, 1'b0, 1'b1, 1'b0)));
    vecs.push_back(v("timeout_to_intro",  1'b1, 1'b0, 9'd100, 9'd100,   60, mk(3'd0, 4'd3, 8'h01, 7'd60, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1)));
    vecs.push_back(v("intro4_fight",      1'b1, 1'b0, 9'd100, 9'd100,   40, mk(3'd1, 4'd3, 8'h01, 7'd60, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
`ifdef MATCH_SUDDEN_DEATH_EN
    vecs.push_back(v("timeout_tie",       1'b1, 1'b0, 9'd80,  9'd80,  1200, mk(3'd4, 4'd3, 8'h01, 7'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v("sudden_resolve",    1'b1, 1'b0, 9'd80,  9'd70,     1, mk(3'd2, 4'd3, 8'h02, 7'd0,  2'd0, 1'b1, 1'b0, 1'b1, 1'b0)));
`else
    vecs.push_back(v("timeout_tie",       1'b1, 1'b0, 9'd80,  9'd80,  1200, mk(3'd2, 4'd3, 8'h01, 7'd0,  2'd0, 1'b0, 1'b1, 1'b1, 1'b0)));
    vecs.push_back(v("tie_end_holds",     1'b1, 1'b0, 9'd80,  9'd70,     1, mk(3'd2, 4'd3, 8'h01, 7'd0,  2'd0, 1'b0, 1'b1, 1'b1, 1'b0)));
`endif

    reset        = 1'b1;
    bus.tick     = 1'b0;
    bus.hold_req = 1'b0;
    bus.health   = {9'd100, 9'd100};
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_obs("reset_values", rst_o);
    check_pop();
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Hold reset from ROUND_END, then play to 37 seconds left and pull async reset
    apply(v("hold_from_round_end", 1'b1, 1'b1, 9'd100, 9'd100,  40, rst_o));
    apply(v("refight",             1'b1, 1'b0, 9'd100, 9'd100,  40, mk(3'd1, 4'd1, 8'h00, 7'd60, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    apply(v("secs_37",             1'b1, 1'b0, 9'd100, 9'd100, 460, mk(3'd1, 4'd1, 8'h00, 7'd37, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    reset = 1'b0;
    #1;
    expect_obs("async_reset_no_edge", rst_o);
    check_pop();
    run(3, 1'b1);
    expect_obs("reset_held_with_ticks", rst_o);
    check_pop();
    reset = 1'b1;
    apply(v("post_reset_intro", 1'b1, 1'b0, 9'd100, 9'd100, 39, rst_o));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
